// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store over valid/ready handshakes with a
// fixed accept-to-response latency. Handles byte/half/word lanes and sign/zero extension.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned or reserved-size accesses fault).
module dmem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int unsigned Words   = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    capture;
  logic                    commit;

  logic [DATA_WIDTH-1:0]   mem [Words];

  logic                    fault;
  logic [1:0]              eff_size;
  logic [4:0]              shift;
  logic [31:0]             mask;
  logic [31:0]             rd_word;
  logic [31:0]             wr_word;
  logic [31:0]             sel;
  logic [31:0]             load_ext;

  // Address bits above the decoded range are ignored, so the array wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_WIDTH];

  assign req_ready_o = (state_q == StIdle) && !rst;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign commit      = (state_q == StWait) && (cnt_q == 4'd0);

  // Fault decode, lane selection, store merge and load extension on the captured request.
  always_comb begin
    fault    = 1'b0;
    eff_size = size_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    unique case (size_q)
      2'b01:   fault = addr_q[0];
      2'b10:   fault = (addr_q[1:0] != 2'b00);
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
`else
    // Reserved size behaves as a word access.
    if (size_q == 2'b11) eff_size = 2'b10;
`endif
    rd_word = mem[addr_q[ADDR_WIDTH-1:2]];
    shift   = 5'd0;
    mask    = '1;
    unique case (eff_size)
      2'b00: begin
        shift = {addr_q[1:0], 3'b000};
        mask  = 32'h0000_00FF << shift;
      end
      2'b01: begin
        shift = {addr_q[1], 4'b0000};
        mask  = 32'h0000_FFFF << shift;
      end
      default: begin
        shift = 5'd0;
        mask  = '1;
      end
    endcase
    wr_word = (rd_word & ~mask) | ((wdata_q << shift) & mask);
    sel     = (rd_word & mask) >> shift;
    unique case (eff_size)
      2'b00:   load_ext = {{24{sel[7] & ~uns_q}}, sel[7:0]};
      2'b01:   load_ext = {{16{sel[15] & ~uns_q}}, sel[15:0]};
      default: load_ext = sel;
    endcase
  end

  // Next-state logic: accept in idle, count down the latency, hold the response until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_o) begin
          capture = 1'b1;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (we_q || fault) ? '0 : load_ext;
          err_d   = fault;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i[ADDR_WIDTH-1:0];
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
      end
    end
  end

  // Storage array is not reset; a store only lands on its commit edge.
  always_ff @(posedge clk) begin
    if (commit && we_q && !fault && !rst) begin
      mem[addr_q[ADDR_WIDTH-1:2]] <= wr_word;
    end
  end

endmodule
